// File: rtl/tiny_dnn_mac_array_if.sv
// tiny_dnn_mac_array_if: command, weight-write and output-chain signals of the MAC array.
// master drives the commands; slave is the array itself.
interface tiny_dnn_mac_array_if #(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int DEPTH = 1024
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic                 init;
   logic                 write;
   logic [LW-1:0]        wlane;
   logic [AW-1:0]        wa;
   logic signed [DW-1:0] wd;
   logic                 exec;
   logic                 bias;
   logic [AW-1:0]        ra;
   logic signed [DW-1:0] d;
   logic                 update;
   logic                 outr;
   logic signed [DW-1:0] sum_in;
   logic signed [DW-1:0] sum;
   logic                 busy;

   modport master (
      output init, write, wlane, wa, wd, exec, bias, ra, d, update, outr, sum_in,
      input  sum, busy
   );

   modport slave (
      input  init, write, wlane, wa, wd, exec, bias, ra, d, update, outr, sum_in,
      output sum, busy
   );
endinterface

// File: rtl/tiny_dnn_mac_array.sv
// tiny_dnn_mac_array: LANES fixed-point MAC lanes with private weight RAMs and a shift-out chain.
// Define TINY_DNN_MAC_SAT_EN to saturate the output conversion instead of wrapping it.
module tiny_dnn_mac_array #(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int ACCW  = 40,
   parameter int DEPTH = 1024
) (
   input logic                 clk,
   input logic                 reset,
   tiny_dnn_mac_array_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PW = 2 * DW;
   localparam int HS = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic [ACCW-1:0] HALF = (FRAC > 0) ? (ACCW'(1) << HS) : '0;

   logic signed [DW-1:0]   mem [LANES][DEPTH];

   logic                   vld_p0_q, init_p0_q, term_p0_q, bias_p0_q, wr_p0_q;
   logic                   vld_p1_q, init_p1_q, term_p1_q, bias_p1_q;
   logic                   vld_p2_q, init_p2_q, term_p2_q;
   logic [AW-1:0]          ra_p0_q, wa_p0_q;
   logic [LW-1:0]          wlane_p0_q;
   logic signed [DW-1:0]   d_p0_q, wd_p0_q, d_p1_q;
   logic signed [DW-1:0]   w_p1_q    [LANES];
   logic signed [PW-1:0]   prod_p2_q [LANES];
   logic signed [ACCW-1:0] acc_q     [LANES];
   logic signed [ACCW-1:0] acc_d     [LANES];
   logic signed [DW-1:0]   chain_q   [LANES];
   logic signed [DW-1:0]   chain_d   [LANES];
   logic [AW-1:0]          rd_addr;

   function automatic logic signed [ACCW-1:0] round_acc(input logic signed [ACCW-1:0] a);
      return (a + $signed(HALF)) >>> FRAC;
   endfunction

   function automatic logic signed [DW-1:0] to_out(input logic signed [ACCW-1:0] a);
      logic signed [ACCW-1:0] r;
      r = round_acc(a);
`ifdef TINY_DNN_MAC_SAT_EN
      if (r[ACCW-1:DW-1] != {(ACCW-DW+1){r[ACCW-1]}})
         to_out = r[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         to_out = r[DW-1:0];
`else
      to_out = r[DW-1:0];
`endif
   endfunction

   // Weight writes are staged one cycle so a same-cycle read sees the old word.
   assign rd_addr = bias_p0_q ? AW'(DEPTH - 1) : ra_p0_q;

   always_ff @(posedge clk) begin
      ra_p0_q    <= bus.ra;
      d_p0_q     <= bus.d;
      wa_p0_q    <= bus.wa;
      wd_p0_q    <= bus.wd;
      wlane_p0_q <= bus.wlane;
      // p0 -> p1: weight read and data alignment
      d_p1_q     <= d_p0_q;
      for (int l = 0; l < LANES; l++) begin
         if (wr_p0_q && (wlane_p0_q == LW'(l)))
            mem[l][wa_p0_q] <= wd_p0_q;
         w_p1_q[l] <= mem[l][rd_addr];
      end
      // p1 -> p2: full-precision product, or the bias word scaled to product format
      for (int l = 0; l < LANES; l++)
         prod_p2_q[l] <= bias_p1_q ? (PW'(w_p1_q[l]) <<< FRAC) : PW'(w_p1_q[l]) * PW'(d_p1_q);
   end

   // p2 -> accumulator: init replaces the running sum with this op's term
   always_comb begin
      acc_d = acc_q;
      if (vld_p2_q)
         for (int l = 0; l < LANES; l++)
            acc_d[l] = (init_p2_q ? '0 : acc_q[l]) + (term_p2_q ? ACCW'(prod_p2_q[l]) : '0);
   end

   always_comb begin
      chain_d = chain_q;
      if (bus.update) begin
         for (int l = 0; l < LANES; l++)
            chain_d[l] = to_out(acc_q[l]);
      end else if (bus.outr) begin
         chain_d[0] = bus.sum_in;
         for (int l = 1; l < LANES; l++)
            chain_d[l] = chain_q[l-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0_q  <= 1'b0;
         init_p0_q <= 1'b0;
         term_p0_q <= 1'b0;
         bias_p0_q <= 1'b0;
         wr_p0_q   <= 1'b0;
         vld_p1_q  <= 1'b0;
         init_p1_q <= 1'b0;
         term_p1_q <= 1'b0;
         bias_p1_q <= 1'b0;
         vld_p2_q  <= 1'b0;
         init_p2_q <= 1'b0;
         term_p2_q <= 1'b0;
         acc_q     <= '{default: '0};
         chain_q   <= '{default: '0};
      end else begin
         vld_p0_q  <= bus.init | bus.exec | bus.bias;
         init_p0_q <= bus.init;
         term_p0_q <= bus.exec | bus.bias;
         bias_p0_q <= bus.bias & ~bus.exec;
         wr_p0_q   <= bus.write;
         vld_p1_q  <= vld_p0_q;
         init_p1_q <= init_p0_q;
         term_p1_q <= term_p0_q;
         bias_p1_q <= bias_p0_q;
         vld_p2_q  <= vld_p1_q;
         init_p2_q <= init_p1_q;
         term_p2_q <= term_p1_q;
         acc_q     <= acc_d;
         chain_q   <= chain_d;
      end
   end

   assign bus.sum  = chain_q[LANES-1];
   assign bus.busy = vld_p0_q | vld_p1_q | vld_p2_q;
endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
// tb_tiny_dnn_mac_array: scoreboard bench for the MAC array with a behavioural lane/chain model.
// Honours TINY_DNN_MAC_SAT_EN when forming expected conversions.
module tb_tiny_dnn_mac_array;
   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int FRAC  = 8;
   localparam int ACCW  = 40;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int LW    = 2;

   logic   clk = 1'b0;
   logic   reset;
   int     n_cmp = 0;
   int     n_bad = 0;
   longint wm [LANES][DEPTH];
   longint am [LANES];
   longint cm [LANES];
   longint sb [$];

   tiny_dnn_mac_array_if #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) bus ();

   tiny_dnn_mac_array #(
      .LANES(LANES), .DW(DW), .FRAC(FRAC), .ACCW(ACCW), .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint wrap_acc(input longint a);
      return (a <<< (64 - ACCW)) >>> (64 - ACCW);
   endfunction

   function automatic longint cvt_model(input longint a);
      longint r;
      r = (a + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef TINY_DNN_MAC_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`else
      r = (r <<< (64 - DW)) >>> (64 - DW);
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.init = 1'b0; bus.write = 1'b0; bus.wlane = '0; bus.wa = '0; bus.wd = '0;
      bus.exec = 1'b0; bus.bias = 1'b0; bus.ra = '0; bus.d = '0;
      bus.update = 1'b0; bus.outr = 1'b0; bus.sum_in = '0;
   endtask

   task automatic wr(input int lane, input int addr, input longint val);
      bus.write = 1'b1; bus.wlane = LW'(lane); bus.wa = AW'(addr); bus.wd = DW'(val);
      wm[lane][addr] = val;
      tick();
      bus.write = 1'b0;
   endtask

   // Drives one op and applies it to the model; exec wins over bias.
   task automatic drive_op(input bit i, input bit e, input bit b, input int ra, input longint dv);
      longint term;
      bus.init = i; bus.exec = e; bus.bias = b; bus.ra = AW'(ra); bus.d = DW'(dv);
      for (int l = 0; l < LANES; l++) begin
         term = e ? wm[l][ra] * dv : (b ? (wm[l][DEPTH-1] <<< FRAC) : 0);
         am[l] = wrap_acc(i ? term : am[l] + term);
      end
   endtask

   task automatic op(input bit i, input bit e, input bit b, input int ra, input longint dv);
      drive_op(i, e, b, ra, dv);
      tick();
      clear_in();
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check(tag, bus.busy, 0);
   endtask

   task automatic pop_cmp(input string tag);
      if (sb.size() == 0) check({tag, "_empty"}, 1, 0);
      else check(tag, bus.sum, sb.pop_front());
   endtask

   // Update (optionally with outr) then shift the whole chain out.
   task automatic read_out(input string tag, input bit with_outr);
      bus.update = 1'b1; bus.outr = with_outr;
      for (int l = 0; l < LANES; l++) cm[l] = cvt_model(am[l]);
      sb.push_back(cm[LANES-1]);
      tick();
      clear_in();
      pop_cmp($sformatf("%s_upd", tag));
      for (int j = 0; j < LANES; j++) begin
         bus.outr = 1'b1; bus.sum_in = DW'(100 + j);
         for (int l = LANES - 1; l > 0; l--) cm[l] = cm[l-1];
         cm[0] = 100 + j;
         sb.push_back(cm[LANES-1]);
         tick();
         clear_in();
         pop_cmp($sformatf("%s_sh%0d", tag, j));
      end
   endtask

   initial begin
      clear_in();
      for (int l = 0; l < LANES; l++) am[l] = 0;
      reset = 1'b1;
      repeat (3) tick();
      check("rst_sum", bus.sum, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b0;
      tick();

      for (int k = 0; k < LANES; k++) wr(k, 5, 256 * (k + 1));
      op(1, 0, 0, 0, 0);
      op(0, 1, 0, 5, 512);
      wait_idle("mac_idle");
      read_out("mac", 1'b0);

      for (int k = 0; k < LANES; k++) wr(k, DEPTH - 1, 128);
      op(1, 0, 1, 0, 0);
      check("bias_busy1", bus.busy, 1);
      tick(); check("bias_busy2", bus.busy, 1);
      tick(); check("bias_busy3", bus.busy, 1);
      tick(); check("bias_busy_off", bus.busy, 0);
      read_out("bias", 1'b0);

      op(1, 1, 1, 5, 256);
      wait_idle("exbias_idle");
      read_out("exbias", 1'b0);

      for (int k = 0; k < LANES; k++) wr(k, 9, 256);
      for (int i = 0; i < 10; i++) op(i == 0, 1, 0, 9, 256);
      check("b2b_busy1", bus.busy, 1);
      tick(); check("b2b_busy2", bus.busy, 1);
      tick(); check("b2b_busy3", bus.busy, 1);
      tick(); check("b2b_busy_off", bus.busy, 0);
      read_out("b2b", 1'b0);

      for (int k = 0; k < LANES; k++) wr(k, 3, 32767);
      op(1, 1, 0, 3, 32767);
      for (int i = 0; i < 3; i++) op(0, 1, 0, 3, 32767);
      wait_idle("sat_idle");
      read_out("sat", 1'b0);

      op(0, 1, 0, 5, 512);
      reset = 1'b1;
      tick();
      check("rstmid_busy_in", bus.busy, 0);
      check("rstmid_sum_in", bus.sum, 0);
      reset = 1'b0;
      for (int l = 0; l < LANES; l++) am[l] = 0;
      repeat (4) tick();
      check("rstmid_busy_out", bus.busy, 0);
      read_out("rstmid", 1'b0);

      op(1, 1, 0, 5, 256);
      wait_idle("uo_idle");
      read_out("uo", 1'b1);

      for (int k = 0; k < LANES; k++) wr(k, 7, 256);
      bus.write = 1'b1; bus.wlane = '0; bus.wa = AW'(7); bus.wd = DW'(1024);
      drive_op(1, 1, 0, 7, 256);
      wm[0][7] = 1024;
      tick();
      clear_in();
      wait_idle("rdw_idle");
      read_out("rdw_old", 1'b0);
      op(1, 1, 0, 7, 256);
      wait_idle("rdw_idle2");
      read_out("rdw_new", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
